// File: rtl/csr_counter_bank.sv
// Bank of NUM_CNT CSR-visible counters with per-counter inhibit and sticky
// wrap flags; each counter is exposed as a 32-bit low half and a high half.

module csr_counter_lane #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf
);
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    // a write beats a same-cycle increment and re-arms the wrap flag
    if (wr_lo) begin
      cnt_d = {cnt_q[CNT_WIDTH-1:32], wdata};
      ovf_d = 1'b0;
    end else if (wr_hi) begin
      cnt_d = {wdata[CNT_WIDTH-33:0], cnt_q[31:0]};
      ovf_d = 1'b0;
    end else if (inc_en) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (&cnt_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

module csr_counter_bank #(
  parameter int          NUM_CNT   = 3,
  parameter int          CNT_WIDTH = 64,
  parameter logic [11:0] BASE_ADDR = 12'hB00,
  parameter logic [11:0] HI_OFFSET = 12'h080,
  parameter logic [11:0] INH_ADDR  = 12'h320
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] inc,
  input  logic [11:0]        csr_addr,
  input  logic               csr_rd,
  input  logic               csr_we,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_rvalid,
  output logic               csr_hit,
  output logic [NUM_CNT-1:0] ovf
);
  logic [NUM_CNT-1:0]                lo_sel, hi_sel;
  logic                              inh_sel;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt;
  logic [NUM_CNT-1:0]                inh_d, inh_q;
  logic [31:0]                       rdata_d, rdata_q;
  logic                              hit_d, hit_q;
  logic                              rvalid_d, rvalid_q;

  assign inh_sel = (csr_addr == INH_ADDR);

  genvar g;
  for (g = 0; g < NUM_CNT; g++) begin : g_lane
    assign lo_sel[g] = (csr_addr == BASE_ADDR + 12'(g));
    assign hi_sel[g] = (csr_addr == BASE_ADDR + HI_OFFSET + 12'(g));

    csr_counter_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .inc_en (inc[g] & ~inh_q[g]),
      .wr_lo  (csr_we & lo_sel[g]),
      .wr_hi  (csr_we & hi_sel[g]),
      .wdata  (csr_wdata),
      .cnt    (cnt[g]),
      .ovf    (ovf[g])
    );
  end

  always_comb begin
    inh_d = inh_q;
    if (csr_we && inh_sel) inh_d = csr_wdata[NUM_CNT-1:0];
  end

  // read data reflects state before this edge's write/increment
  always_comb begin
    rdata_d  = rdata_q;
    hit_d    = hit_q;
    rvalid_d = 1'b0;
    if (csr_rd) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      hit_d    = 1'b0;
      if (inh_sel) begin
        rdata_d = 32'(inh_q);
        hit_d   = 1'b1;
      end
      for (int i = 0; i < NUM_CNT; i++) begin
        if (lo_sel[i]) begin
          rdata_d = cnt[i][31:0];
          hit_d   = 1'b1;
        end
        if (hi_sel[i]) begin
          rdata_d = 32'(cnt[i][CNT_WIDTH-1:32]);
          hit_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inh_q    <= '0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      inh_q    <= inh_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign csr_rdata  = rdata_q;
  assign csr_hit    = hit_q;
  assign csr_rvalid = rvalid_q;
endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed and randomized checks of csr_counter_bank against a reference model.

module tb_csr_counter_bank;
  localparam int          N    = 3;
  localparam logic [11:0] BASE = 12'hB00;
  localparam logic [11:0] HOFF = 12'h080;
  localparam logic [11:0] INH  = 12'h320;
  localparam logic [63:0] LO_MASK = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  inc = '0;
  logic [11:0]   csr_addr = '0;
  logic          csr_rd = 1'b0;
  logic          csr_we = 1'b0;
  logic [31:0]   csr_wdata = '0;
  logic [31:0]   csr_rdata;
  logic          csr_rvalid;
  logic          csr_hit;
  logic [N-1:0]  ovf;

  csr_counter_bank dut (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc),
    .csr_addr   (csr_addr),
    .csr_rd     (csr_rd),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_rvalid (csr_rvalid),
    .csr_hit    (csr_hit),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state: counters as plain 64-bit numbers
  logic [63:0]  m_cnt [N];
  logic [N-1:0] m_ovf, m_inh;
  logic [31:0]  e_rdata;
  logic         e_hit, e_rvalid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] i_inc, input logic [11:0] a,
                       input logic rd, input logic we, input logic [31:0] wd);
    rst = r; inc = i_inc; csr_addr = a; csr_rd = rd; csr_we = we; csr_wdata = wd;
    if (!r) begin
      for (int k = 0; k < N; k++) m_cnt[k] = 64'd0;
      m_ovf = '0; m_inh = '0;
      e_rdata = '0; e_hit = 1'b0; e_rvalid = 1'b0;
    end else begin
      e_rvalid = rd;
      if (rd) begin
        e_hit = 1'b0; e_rdata = '0;
        if (a == INH) begin e_hit = 1'b1; e_rdata = 32'(m_inh); end
        for (int k = 0; k < N; k++) begin
          if (a == BASE + 12'(k))        begin e_hit = 1'b1; e_rdata = 32'(m_cnt[k] % 64'h1_0000_0000); end
          if (a == BASE + HOFF + 12'(k)) begin e_hit = 1'b1; e_rdata = 32'(m_cnt[k] / 64'h1_0000_0000); end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (we && a == BASE + 12'(k)) begin
          m_cnt[k] = (m_cnt[k] & ~LO_MASK) + 64'(wd);
          m_ovf[k] = 1'b0;
        end else if (we && a == BASE + HOFF + 12'(k)) begin
          m_cnt[k] = (64'(wd) * 64'h1_0000_0000) + (m_cnt[k] & LO_MASK);
          m_ovf[k] = 1'b0;
        end else if (i_inc[k] && !m_inh[k]) begin
          if (m_cnt[k] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[k] = 1'b1;
          m_cnt[k] = m_cnt[k] + 64'd1;
        end
      end
      if (we && a == INH) m_inh = wd[N-1:0];
    end
    @(posedge clk); #1;
    chk("rvalid", csr_rvalid, e_rvalid);
    chk("rdata",  csr_rdata,  e_rdata);
    chk("hit",    csr_hit,    e_hit);
    chk("ovf",    ovf,        m_ovf);
  endtask

  task automatic rd(input logic [11:0] a);
    cycle(1'b1, '0, a, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cycle(1'b1, '0, a, 1'b0, 1'b1, d);
  endtask

  initial begin
    logic [11:0] a;
    int sel;

    // reset with busy inputs: nothing may take effect
    cycle(1'b0, '1, BASE, 1'b1, 1'b1, 32'hDEAD_BEEF);
    cycle(1'b0, '1, INH,  1'b1, 1'b1, 32'h7);

    // cycle count then sampled read
    repeat (10) cycle(1'b1, 3'b001, 12'h000, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 3'b001, BASE, 1'b1, 1'b0, 32'd0);
    chk("count10_rdata", csr_rdata, 64'd10);
    chk("count10_hit",   csr_hit,   64'd1);

    // carry from low into high half, no wrap
    wr(BASE, 32'hFFFF_FFFF);
    wr(BASE + HOFF, 32'd0);
    cycle(1'b1, 3'b001, 12'h000, 1'b0, 1'b0, 32'd0);
    rd(BASE);
    chk("carry_lo", csr_rdata, 64'd0);
    rd(BASE + HOFF);
    chk("carry_hi", csr_rdata, 64'd1);
    chk("carry_ovf", ovf[0], 64'd0);

    // full wrap sets ovf; a write clears it
    wr(BASE, 32'hFFFF_FFFF);
    wr(BASE + HOFF, 32'hFFFF_FFFF);
    cycle(1'b1, 3'b001, 12'h000, 1'b0, 1'b0, 32'd0);
    chk("wrap_ovf_set", ovf[0], 64'd1);
    rd(BASE);
    chk("wrap_lo", csr_rdata, 64'd0);
    rd(BASE + HOFF);
    chk("wrap_hi", csr_rdata, 64'd0);
    wr(BASE, 32'd5);
    chk("wrap_ovf_clr", ovf[0], 64'd0);

    // inhibit counter 1
    for (int k = 0; k < N; k++) begin
      wr(BASE + 12'(k), 32'(100 * (k + 1)));
      wr(BASE + HOFF + 12'(k), 32'd0);
    end
    wr(INH, 32'h2);
    repeat (4) cycle(1'b1, 3'b111, 12'h000, 1'b0, 1'b0, 32'd0);
    rd(BASE);
    chk("inh_c0", csr_rdata, 64'd104);
    rd(BASE + 12'd1);
    chk("inh_c1", csr_rdata, 64'd200);
    rd(BASE + 12'd2);
    chk("inh_c2", csr_rdata, 64'd304);
    rd(INH);
    chk("inh_read", csr_rdata, 64'd2);

    // write beats increment; miss; same-cycle read+write sees old value
    cycle(1'b1, 3'b111, BASE, 1'b0, 1'b1, 32'd7);
    rd(BASE);
    chk("wr_prio", csr_rdata, 64'd7);
    rd(12'h123);
    chk("miss_rvalid", csr_rvalid, 64'd1);
    chk("miss_hit",    csr_hit,    64'd0);
    chk("miss_rdata",  csr_rdata,  64'd0);
    cycle(1'b1, 3'b001, BASE, 1'b1, 1'b1, 32'h55);
    chk("rdwr_old", csr_rdata, 64'd7);
    rd(BASE);
    chk("rdwr_new", csr_rdata, 64'h55);

    // randomized traffic
    wr(INH, 32'd0);
    repeat (400) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)       a = BASE + 12'(sel);
      else if (sel < 6)  a = BASE + HOFF + 12'(sel - 3);
      else if (sel == 6) a = INH;
      else               a = 12'($urandom);
      cycle(($urandom % 60) != 0, N'($urandom), a, 1'($urandom), ($urandom % 3) == 0,
            (($urandom % 3) == 0) ? 32'hFFFF_FFFF : $urandom);
    end

    // reset while ovf is set and counting is under way
    wr(INH, 32'd0);
    wr(BASE + 12'd1, 32'hFFFF_FFFF);
    wr(BASE + HOFF + 12'd1, 32'hFFFF_FFFF);
    cycle(1'b1, 3'b111, 12'h000, 1'b0, 1'b0, 32'd0);
    chk("pre_rst_ovf", ovf[1], 64'd1);
    wr(INH, 32'h5);
    repeat (3) cycle(1'b1, 3'b111, 12'h000, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 3'b111, BASE, 1'b1, 1'b1, 32'hABCD);
    chk("rst_ovf", ovf, 64'd0);
    for (int k = 0; k < N; k++) begin
      rd(BASE + 12'(k));
      chk("rst_lo", csr_rdata, 64'd0);
      rd(BASE + HOFF + 12'(k));
      chk("rst_hi", csr_rdata, 64'd0);
    end
    rd(INH);
    chk("rst_inh", csr_rdata, 64'd0);
    cycle(1'b1, 3'b001, 12'h000, 1'b0, 1'b0, 32'd0);
    rd(BASE);
    chk("resume", csr_rdata, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_counter_bank.md
CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CNT, default 3: number of counters, legal range 1..8.
REQ-002 SHALL have parameter CNT_WIDTH, default 64: counter width, legal range 33..64.
REQ-003 SHALL have parameter BASE_ADDR, default 12'hB00: CSR address of counter 0 low half.
REQ-004 SHALL have parameter HI_OFFSET, default 12'h080: offset from a low-half address to its high-half address.
REQ-005 SHALL have parameter INH_ADDR, default 12'h320: CSR address of the inhibit register.
REQ-006 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port inc, input, NUM_CNT: per-counter increment strobe (inc[0] tied 1 at top for cycle count).
REQ-009 SHALL have port csr_addr, input, 12: CSR address.
REQ-010 SHALL have port csr_rd, input, 1: read request.
REQ-011 SHALL have port csr_we, input, 1: write request.
REQ-012 SHALL have port csr_wdata, input, 32: write data.
REQ-013 SHALL have port csr_rdata, output, 32: registered read data.
REQ-014 SHALL have port csr_rvalid, output, 1: one-cycle pulse, the cycle after csr_rd.
REQ-015 SHALL have port csr_hit, output, 1: registered with csr_rdata; address decoded to this block.
REQ-016 SHALL have port ovf, output, NUM_CNT: sticky per-counter wrap flags.

Function
REQ-017 SHALL decode counter i low at BASE_ADDR+i, high at BASE_ADDR+HI_OFFSET+i, inhibit at INH_ADDR; all other addresses miss.
REQ-018 SHALL increment counter i by 1 each cycle inc[i]=1 and inhibit[i]=0; otherwise hold.
REQ-019 SHALL wrap counter from 2^CNT_WIDTH-1 to 0 and set ovf[i] in the same edge.
REQ-020 SHALL clear ovf[i] on any write to counter i (low or high); ovf is otherwise sticky.
REQ-021 SHALL, on low-half write, load bits[31:0] from csr_wdata and keep upper bits.
REQ-022 SHALL, on high-half write, load bits[CNT_WIDTH-1:32] from csr_wdata[CNT_WIDTH-33:0], ignore remaining wdata bits, keep low bits.
REQ-023 SHALL give a write priority over a same-cycle increment; the increment is dropped, the written value stands.
REQ-024 SHALL, on inhibit write, load inhibit[NUM_CNT-1:0] from csr_wdata; inhibit reads return it zero-extended.
REQ-025 SHALL register reads: csr_rdata, csr_hit, csr_rvalid valid exactly 1 cycle after csr_rd=1, sampling the pre-edge value (before same-cycle write/increment).
REQ-026 SHALL return high-half reads zero-extended above bit CNT_WIDTH-33.
REQ-027 SHALL on a miss drive csr_hit=0, csr_rdata=0, csr_rvalid=1; writes to missed addresses have no effect.
REQ-028 SHALL hold csr_rdata and csr_hit when csr_rd=0; csr_rvalid=0.
REQ-029 SHALL accept csr_rd and csr_we in the same cycle, independently, with no stall.

Reset
REQ-030 SHALL, while rst=0 at a clock edge, clear all counters, inhibit, ovf, csr_rdata, csr_hit and csr_rvalid to 0.
REQ-031 SHALL ignore inc, csr_rd and csr_we in reset cycles; a reset mid-count discards the count; counting resumes the first edge after rst=1.

Verification
REQ-032 SHALL cover: reset release, inc[0]=1 for 10 cycles, read BASE_ADDR -> rdata=10 (sampled value), hit=1, rvalid one cycle later.
REQ-033 SHALL cover: write low=32'hFFFF_FFFF, high=0 to counter 0, one increment -> low reads 0, high reads 1, ovf[0]=0.
REQ-034 SHALL cover: CNT_WIDTH=64, load all ones, one increment -> value 0, ovf[0]=1; then write low=5 -> ovf[0]=0.
REQ-035 SHALL cover: write inhibit=3'b010, inc=3'b111 for 4 cycles -> counter1 unchanged, counters 0 and 2 advanced by 4.
REQ-036 SHALL cover: write 7 with inc asserted same cycle -> counter reads 7; and read 12'h123 -> hit=0, rdata=0, rvalid=1.
REQ-037 SHALL cover: rst=0 asserted mid-count with ovf set -> all counters, inhibit, ovf read 0 after release.
